map_tile_renderer: RTL

- Parametrised successor to the 4x4 grid-to-colour-map converter of the matching game.
- On `start`, snapshots the logic map, cursor and selections, then streams one pixel per handshake in raster order over a (ROWS*TILE) x (COLS*TILE) image.
- Output is a valid/ready pixel stream, not a full-frame array, so it feeds the framebuffer/VGA writer directly.
- Adds over the previous block: hidden/matched cell states, selection borders, and arbitrary grid and tile size.

---
 rtl/map_tile_renderer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/map_tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : map_tile_renderer
//  Description : Renders a ROWS x COLS logic map into a (ROWS*TILE) x
//                (COLS*TILE) pixel image. The image leaves one pixel per
//                valid/ready handshake, in raster order. Cells can be hidden
//                or matched, and the block draws a cursor dot and selection
//                borders. All inputs are snapshotted on start.
//  Options     : define CURSOR_BLINK_EN to blink the cursor every
//                BLINK_FRAMES frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module map_tile_renderer #(
    parameter int                 COLS         = 4,
    parameter int                 ROWS         = 4,
    parameter int                 TILE         = 3,
    parameter int                 CELL_W       = 5,
    parameter int                 COLOR_W      = 3,
    parameter logic [COLOR_W-1:0] HIDDEN_COLOR = 3'b110,
    parameter logic [COLOR_W-1:0] CURSOR_COLOR = 3'b111,
    parameter logic [COLOR_W-1:0] SEL_COLOR    = 3'b101,
    parameter int                 BLINK_FRAMES = 8,
    localparam int                N            = ROWS * COLS,
    localparam int                IDX_W        = $clog2(N),
    localparam int                X_W          = $clog2(COLS * TILE),
    localparam int                Y_W          = $clog2(ROWS * TILE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [N*CELL_W-1:0]     logic_map,
    input  logic [IDX_W-1:0]        cursor,
    input  logic [2*(IDX_W+1)-1:0]  selected,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [X_W-1:0]          pix_x,
    output logic [Y_W-1:0]          pix_y,
    output logic [COLOR_W-1:0]      pix_color,
    output logic                    busy,
    output logic                    done
);

    localparam int                SUB_W      = $clog2(TILE);
    localparam int                SEL_W      = IDX_W + 1;
    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(TILE - 1);
    localparam logic [SUB_W-1:0]  SUB_MID    = SUB_W'(TILE / 2);
    localparam logic [X_W-1:0]    X_LAST     = X_W'(COLS * TILE - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(ROWS * TILE - 1);
    localparam logic [IDX_W-1:0]  ROW_REWIND = IDX_W'(COLS - 1);
    localparam logic [IDX_W:0]    N_EXT      = SEL_W'(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [N*CELL_W-1:0]      map_q, map_d;
    logic [IDX_W-1:0]         cursor_q, cursor_d;
    logic [2*SEL_W-1:0]       sel_q, sel_d;
    logic [SUB_W-1:0]         sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [IDX_W-1:0]         cell_q, cell_d;
    logic [X_W-1:0]           pix_x_q, pix_x_d;
    logic [Y_W-1:0]           pix_y_q, pix_y_d;
    logic [COLOR_W-1:0]       pix_color_q, pix_color_d;
    logic                     pix_valid_q, pix_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     load;
    logic                     w_cursor_on;
    logic [CELL_W-1:0]        w_cell_bits;
    logic                     w_on_centre, w_on_edge, w_cursor_hit, w_sel_hit;
    logic [COLOR_W-1:0]       w_color;

`ifdef CURSOR_BLINK_EN
    localparam int            BLINK_W = $clog2(BLINK_FRAMES) + 1;
    logic [BLINK_W-1:0]       frame_cnt_q, frame_cnt_d;
    assign w_cursor_on = ~frame_cnt_q[BLINK_W-1];
`else
    assign w_cursor_on = 1'b1;
`endif

    // Frame sequencing, snapshot capture and raster counter advance
    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        cursor_d    = cursor_q;
        sel_d       = sel_q;
        sub_x_d     = sub_x_q;
        sub_y_d     = sub_y_q;
        cell_d      = cell_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        load        = 1'b0;
`ifdef CURSOR_BLINK_EN
        frame_cnt_d = frame_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    map_d       = logic_map;
                    cursor_d    = cursor;
                    sel_d       = selected;
                    sub_x_d     = '0;
                    sub_y_d     = '0;
                    cell_d      = '0;
                    pix_x_d     = '0;
                    pix_y_d     = '0;
                    pix_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    load        = 1'b1;
                end
            end
            S_RUN: begin
                if (pix_valid_q && pix_ready) begin
                    if (pix_x_q == X_LAST && pix_y_q == Y_LAST) begin
                        state_d     = S_DONE;
                        pix_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (pix_x_q == X_LAST) begin
                            // End of a pixel row: step back to the row's first
                            // cell, or move on to the next tile row.
                            pix_x_d = '0;
                            sub_x_d = '0;
                            pix_y_d = pix_y_q + Y_W'(1);
                            if (sub_y_q == SUB_LAST) begin
                                sub_y_d = '0;
                                cell_d  = cell_q + IDX_W'(1);
                            end else begin
                                sub_y_d = sub_y_q + SUB_W'(1);
                                cell_d  = cell_q - ROW_REWIND;
                            end
                        end else begin
                            pix_x_d = pix_x_q + X_W'(1);
                            if (sub_x_q == SUB_LAST) begin
                                sub_x_d = '0;
                                cell_d  = cell_q + IDX_W'(1);
                            end else begin
                                sub_x_d = sub_x_q + SUB_W'(1);
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
`ifdef CURSOR_BLINK_EN
                frame_cnt_d = frame_cnt_q + BLINK_W'(1);
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Colour for the pixel the counters present next, from the snapshot
    always_comb begin
        w_cell_bits  = map_d[cell_d*CELL_W +: CELL_W];
        w_on_centre  = (sub_x_d == SUB_MID) && (sub_y_d == SUB_MID);
        w_on_edge    = (sub_x_d == '0) || (sub_x_d == SUB_LAST) ||
                       (sub_y_d == '0) || (sub_y_d == SUB_LAST);
        w_cursor_hit = w_cursor_on && ({1'b0, cursor_d} < N_EXT) &&
                       (cursor_d == cell_d) && w_on_centre;
        w_sel_hit    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w_sel_hit = w_sel_hit |
                        (sel_d[k*SEL_W + IDX_W] &&
                         ({1'b0, sel_d[k*SEL_W +: IDX_W]} < N_EXT) &&
                         (sel_d[k*SEL_W +: IDX_W] == cell_d));
        end
        if (w_cursor_hit)
            w_color = CURSOR_COLOR;
        else if (w_sel_hit && w_on_edge)
            w_color = SEL_COLOR;
        else if (w_cell_bits[4])
            w_color = '0;
        else if (!w_cell_bits[3])
            w_color = HIDDEN_COLOR;
        else
            w_color = COLOR_W'(w_cell_bits[2:0]);
        pix_color_d = load ? w_color : pix_color_q;
    end

    // State and output registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            map_q       <= '0;
            cursor_q    <= '0;
            sel_q       <= '0;
            sub_x_q     <= '0;
            sub_y_q     <= '0;
            cell_q      <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CURSOR_BLINK_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            cursor_q    <= cursor_d;
            sel_q       <= sel_d;
            sub_x_q     <= sub_x_d;
            sub_y_q     <= sub_y_d;
            cell_q      <= cell_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CURSOR_BLINK_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
